// File: rtl/wall_clk_counter_bank.sv
// Multi-channel wall-clock / event counter bank with a shared 1 us prescaler,
// atomic all-channel snapshot and sticky per-channel overflow flags.
module wall_clk_counter_bank #(
  parameter int TICK_DIV  = 100,
  parameter int CNT_WIDTH = 32,
  parameter int NUM_CH    = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cnt_clear,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH-1:0]           ch_mode,
  input  logic [NUM_CH-1:0]           ch_event,
  input  logic                        snap_req,
  output logic                        us_tick,
  output logic [NUM_CH*CNT_WIDTH-1:0] cnt_val,
  output logic [NUM_CH*CNT_WIDTH-1:0] snap_val,
  output logic                        snap_valid,
  output logic [NUM_CH-1:0]           ovf
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;

  // us_tick is registered, so it rises one cycle after the prescaler's last count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc   <= '0;
      us_tick <= 1'b0;
    end else if (cnt_clear) begin
      presc   <= '0;
      us_tick <= 1'b0;
    end else begin
      us_tick <= (presc == PRESC_LAST);
      presc   <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf_r;
    logic                 inc;

    assign inc = ch_en[i] & (ch_mode[i] ? ch_event[i] : us_tick);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt   <= '0;
        ovf_r <= 1'b0;
      end else if (cnt_clear) begin
        cnt   <= '0;
        ovf_r <= 1'b0;
      end else if (inc) begin
        cnt <= cnt + CNT_WIDTH'(1);
        if (&cnt) ovf_r <= 1'b1;
      end
    end

    assign cnt_val[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    assign ovf[i] = ovf_r;
  end

  // Snapshot captures the pre-edge counters, so a coincident clear is not seen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      snap_val   <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snap_req;
      if (snap_req) snap_val <= cnt_val;
    end
  end

endmodule

// File: tb/tb_wall_clk_counter_bank.sv
// Self-checking bench for wall_clk_counter_bank: randomized stimulus against a
// cycle-count based reference model (ticks derived from time since last clear).
module tb_wall_clk_counter_bank;

  localparam int TICK_DIV  = 100;
  localparam int CNT_WIDTH = 8;
  localparam int NUM_CH    = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                        clk = 1'b0;
  logic                        resetn;
  logic                        cnt_clear;
  logic [NUM_CH-1:0]           ch_en;
  logic [NUM_CH-1:0]           ch_mode;
  logic [NUM_CH-1:0]           ch_event;
  logic                        snap_req;
  logic                        us_tick;
  logic [NUM_CH*CNT_WIDTH-1:0] cnt_val;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_val;
  logic                        snap_valid;
  logic [NUM_CH-1:0]           ovf;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: counts as plain integers, tick from cycles since clear
  int age;
  bit m_tick;
  int m_cnt [NUM_CH];
  bit m_ovf [NUM_CH];
  int m_snap[NUM_CH];
  bit m_sv;

  wall_clk_counter_bank #(
    .TICK_DIV(TICK_DIV), .CNT_WIDTH(CNT_WIDTH), .NUM_CH(NUM_CH)
  ) dut (
    .clk(clk), .resetn(resetn), .cnt_clear(cnt_clear), .ch_en(ch_en),
    .ch_mode(ch_mode), .ch_event(ch_event), .snap_req(snap_req),
    .us_tick(us_tick), .cnt_val(cnt_val), .snap_val(snap_val),
    .snap_valid(snap_valid), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_WIDTH-1:0] dut_cnt(int i);
    return cnt_val[i*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] dut_snap(int i);
    return snap_val[i*CNT_WIDTH +: CNT_WIDTH];
  endfunction

  task automatic model_reset();
    age = 0; m_tick = 0; m_sv = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 0; m_snap[i] = 0;
    end
  endtask

  // Advance model and DUT by one clock using the currently driven inputs
  task automatic step();
    int old[NUM_CH];
    for (int i = 0; i < NUM_CH; i++) old[i] = m_cnt[i];
    if (cnt_clear) begin
      for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      age = 0; m_tick = 0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_en[i] && (ch_mode[i] ? ch_event[i] : m_tick)) begin
          if (m_cnt[i] == CNT_MAX) begin m_cnt[i] = 0; m_ovf[i] = 1; end
          else m_cnt[i]++;
        end
      age++;
      m_tick = (age % TICK_DIV == 0);
    end
    if (snap_req) m_snap = old;
    m_sv = snap_req;
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    cnt_clear = 1; step(); cnt_clear = 0;
  endtask

  task automatic test_reset();
    resetn = 0; cnt_clear = 0; ch_en = '0; ch_mode = '0; ch_event = '0; snap_req = 0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (us_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_us_tick got %b want 0", us_tick); end
    tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_snap_valid got %b want 0", snap_valid); end
    tests_run++; if (cnt_val !== '0) begin tests_failed++; $display("[TB] FAIL reset_cnt_val got %h want 0", cnt_val); end
    tests_run++; if (snap_val !== '0) begin tests_failed++; $display("[TB] FAIL reset_snap_val got %h want 0", snap_val); end
    tests_run++; if (ovf !== '0) begin tests_failed++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    model_reset();
    resetn = 1;
  endtask

  task automatic test_tick_wall();
    int first = -1;
    int pulses = 0;
    ch_en = '1; ch_mode = '0;
    // The pulse after edge 500 is counted on edge 501
    for (int n = 1; n <= 5 * TICK_DIV + 1; n++) begin
      ch_event = NUM_CH'($urandom);
      step();
      tests_run++;
      if (us_tick !== m_tick) begin tests_failed++; $display("[TB] FAIL tick_cycle%0d got %b want %b", n, us_tick, m_tick); end
      if (us_tick === 1'b1) begin
        pulses++;
        if (first < 0) first = n;
      end
    end
    tests_run++; if (first != TICK_DIV) begin tests_failed++; $display("[TB] FAIL first_tick got %0d want %0d", first, TICK_DIV); end
    tests_run++; if (pulses != 5) begin tests_failed++; $display("[TB] FAIL tick_pulses got %0d want 5", pulses); end
    for (int i = 0; i < NUM_CH; i++) begin
      tests_run++;
      if (dut_cnt(i) !== CNT_WIDTH'(5)) begin tests_failed++; $display("[TB] FAIL wall_cnt_ch%0d got %0d want 5", i, dut_cnt(i)); end
    end
  endtask

  task automatic test_event_mode();
    clear_pulse();
    ch_en = '1; ch_mode = 4'b0010;
    for (int k = 0; k < 37; k++) begin
      ch_event = NUM_CH'($urandom) | 4'b0010;
      ch_en[1] = !(k >= 5 && k < 15);
      step();
    end
    ch_event = '0; ch_en = '1;
    tests_run++; if (dut_cnt(1) !== CNT_WIDTH'(27)) begin tests_failed++; $display("[TB] FAIL event_ch1 got %0d want 27", dut_cnt(1)); end
    for (int i = 0; i < NUM_CH; i++) begin
      tests_run++;
      if (dut_cnt(i) !== CNT_WIDTH'(m_cnt[i])) begin tests_failed++; $display("[TB] FAIL event_model_ch%0d got %0d want %0d", i, dut_cnt(i), m_cnt[i]); end
    end
    for (int n = 0; n < 300; n++) begin
      ch_en = NUM_CH'($urandom); ch_mode = NUM_CH'($urandom); ch_event = NUM_CH'($urandom);
      step();
      for (int i = 0; i < NUM_CH; i++) begin
        tests_run++;
        if (dut_cnt(i) !== CNT_WIDTH'(m_cnt[i])) begin tests_failed++; $display("[TB] FAIL mixed_ch%0d cyc%0d got %0d want %0d", i, n, dut_cnt(i), m_cnt[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    ch_en = 4'b0100; ch_mode = 4'b0100; ch_event = 4'b0100;
    clear_pulse();
    repeat (CNT_MAX) step();
    tests_run++; if (dut_cnt(2) !== CNT_WIDTH'(CNT_MAX)) begin tests_failed++; $display("[TB] FAIL ovf_pre_cnt got %0d want %0d", dut_cnt(2), CNT_MAX); end
    tests_run++; if (ovf !== 4'b0000) begin tests_failed++; $display("[TB] FAIL ovf_pre_flag got %b want 0000", ovf); end
    step();
    tests_run++; if (dut_cnt(2) !== '0) begin tests_failed++; $display("[TB] FAIL ovf_wrap_cnt got %0d want 0", dut_cnt(2)); end
    tests_run++; if (ovf !== 4'b0100) begin tests_failed++; $display("[TB] FAIL ovf_set got %b want 0100", ovf); end
    repeat (5) step();
    tests_run++; if (ovf !== 4'b0100) begin tests_failed++; $display("[TB] FAIL ovf_sticky got %b want 0100", ovf); end
    tests_run++; if (dut_cnt(2) !== CNT_WIDTH'(5)) begin tests_failed++; $display("[TB] FAIL ovf_post_cnt got %0d want 5", dut_cnt(2)); end
    clear_pulse();
    tests_run++; if (ovf !== 4'b0000) begin tests_failed++; $display("[TB] FAIL ovf_clear got %b want 0000", ovf); end
    tests_run++; if (dut_cnt(2) !== '0) begin tests_failed++; $display("[TB] FAIL ovf_clear_cnt got %0d want 0", dut_cnt(2)); end
    ch_en = '0; ch_event = '0;
  endtask

  task automatic test_snap_clear();
    clear_pulse();
    ch_en = 4'b0001; ch_mode = 4'b0001; ch_event = 4'b0001;
    repeat (42) step();
    ch_event = '0;
    tests_run++; if (dut_cnt(0) !== CNT_WIDTH'(42)) begin tests_failed++; $display("[TB] FAIL snapclr_pre got %0d want 42", dut_cnt(0)); end
    snap_req = 1; cnt_clear = 1;
    step();
    snap_req = 0; cnt_clear = 0;
    tests_run++; if (snap_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL snapclr_valid got %b want 1", snap_valid); end
    tests_run++; if (dut_snap(0) !== CNT_WIDTH'(42)) begin tests_failed++; $display("[TB] FAIL snapclr_val got %0d want 42", dut_snap(0)); end
    tests_run++; if (dut_cnt(0) !== '0) begin tests_failed++; $display("[TB] FAIL snapclr_cnt got %0d want 0", dut_cnt(0)); end
    step();
    tests_run++; if (snap_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL snapclr_pulse_len got %b want 0", snap_valid); end
    tests_run++; if (dut_snap(0) !== CNT_WIDTH'(42)) begin tests_failed++; $display("[TB] FAIL snapclr_hold got %0d want 42", dut_snap(0)); end
  endtask

  task automatic test_back_to_back();
    ch_en = '1; ch_mode = '1;
    for (int n = 0; n < 5; n++) begin
      ch_event = NUM_CH'($urandom);
      snap_req = (n < 4);
      step();
      tests_run++;
      if (snap_valid !== m_sv) begin tests_failed++; $display("[TB] FAIL b2b_valid%0d got %b want %b", n, snap_valid, m_sv); end
      for (int i = 0; i < NUM_CH; i++) begin
        tests_run++;
        if (dut_snap(i) !== CNT_WIDTH'(m_snap[i])) begin tests_failed++; $display("[TB] FAIL b2b_snap%0d_ch%0d got %0d want %0d", n, i, dut_snap(i), m_snap[i]); end
      end
    end
    snap_req = 0; ch_event = '0;
  endtask

  task automatic test_clear_at_terminal();
    int guard = 0;
    int gap = -1;
    ch_en = '1; ch_mode = '0; ch_event = '0;
    while (age % TICK_DIV != TICK_DIV - 1 && guard < 2 * TICK_DIV) begin step(); guard++; end
    tests_run++; if (guard >= 2 * TICK_DIV) begin tests_failed++; $display("[TB] FAIL term_reach got timeout want <%0d", 2 * TICK_DIV); end
    clear_pulse();
    tests_run++; if (us_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL term_no_tick got %b want 0", us_tick); end
    for (int n = 1; n <= 2 * TICK_DIV && gap < 0; n++) begin
      step();
      if (us_tick === 1'b1) gap = n;
    end
    tests_run++; if (gap != TICK_DIV) begin tests_failed++; $display("[TB] FAIL term_next_tick got %0d want %0d", gap, TICK_DIV); end
    tests_run++; if (cnt_val !== '0) begin tests_failed++; $display("[TB] FAIL term_cnt got %h want 0", cnt_val); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      ch_en = NUM_CH'($urandom); ch_mode = NUM_CH'($urandom); ch_event = NUM_CH'($urandom);
      cnt_clear = ($urandom_range(0, 399) == 0);
      snap_req = ($urandom_range(0, 7) == 0);
      step();
      tests_run++;
      if (us_tick !== m_tick || snap_valid !== m_sv) begin
        tests_failed++;
        $display("[TB] FAIL rnd_ctl cyc%0d got tick=%b sv=%b want tick=%b sv=%b", n, us_tick, snap_valid, m_tick, m_sv);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        tests_run++;
        if (dut_cnt(i) !== CNT_WIDTH'(m_cnt[i]) || ovf[i] !== m_ovf[i] || dut_snap(i) !== CNT_WIDTH'(m_snap[i])) begin
          tests_failed++;
          $display("[TB] FAIL rnd_ch%0d cyc%0d got cnt=%0d ovf=%b snap=%0d want cnt=%0d ovf=%b snap=%0d",
                   i, n, dut_cnt(i), ovf[i], dut_snap(i), m_cnt[i], m_ovf[i], m_snap[i]);
        end
      end
    end
    cnt_clear = 0; snap_req = 0;
  endtask

  task automatic test_async_reset();
    clear_pulse();
    ch_en = 4'b0101; ch_mode = 4'b0101; ch_event = 4'b0101;
    repeat (CNT_MAX + 20) step();
    snap_req = 1; step(); snap_req = 0;
    tests_run++; if (ovf !== 4'b0101 || dut_cnt(0) === '0) begin tests_failed++; $display("[TB] FAIL arst_pre got ovf=%b cnt0=%0d want ovf=0101 cnt0!=0", ovf, dut_cnt(0)); end
    #3 resetn = 0;
    #1;
    tests_run++; if (cnt_val !== '0 || ovf !== '0) begin tests_failed++; $display("[TB] FAIL arst_cnt got cnt=%h ovf=%b want 0", cnt_val, ovf); end
    tests_run++; if (snap_val !== '0 || snap_valid !== 1'b0 || us_tick !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_misc got snap=%h sv=%b tick=%b want 0", snap_val, snap_valid, us_tick); end
    model_reset();
    @(posedge clk); #1;
    resetn = 1;
    repeat (10) step();
    for (int i = 0; i < NUM_CH; i++) begin
      tests_run++;
      if (dut_cnt(i) !== CNT_WIDTH'(m_cnt[i])) begin tests_failed++; $display("[TB] FAIL arst_resume_ch%0d got %0d want %0d", i, dut_cnt(i), m_cnt[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_tick_wall();
    test_event_mode();
    test_overflow();
    test_snap_clear();
    test_back_to_back();
    test_clear_at_terminal();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
